// File: rtl/mem_loop_ctrl_pkg.sv
// Shared definitions for the nested-loop sequencer: FSM state encoding and
// default parameter values.
package mem_loop_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_INIT  = 3'd1;
  localparam logic [STATE_W-1:0] ST_ENTER = 3'd2;
  localparam logic [STATE_W-1:0] ST_BUSY  = 3'd3;
  localparam logic [STATE_W-1:0] ST_EXIT  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_INIT  = ST_INIT,
    S_ENTER = ST_ENTER,
    S_BUSY  = ST_BUSY,
    S_EXIT  = ST_EXIT,
    S_DONE  = ST_DONE
  } state_t;

  localparam int LOOP_ID_W_DEF   = 5;
  localparam int LOOP_ITER_W_DEF = 16;

endpackage

// File: rtl/mem_loop_ctrl_counter_bank.sv
// Per-level trip-count storage (max) and live iteration counters (cnt).
// The sequencer only ever touches one level at a time, so inc/clear and the
// at_max compare all act on the single selected level.
module loop_counter_bank
  #(
    parameter int LOOP_ID_W   = 5,
    parameter int LOOP_ITER_W = 16
  )
  (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [LOOP_ID_W-1:0]   wr_idx,
    input  logic [LOOP_ITER_W-1:0] wr_data,
    input  logic                   clr_all,
    input  logic [LOOP_ID_W-1:0]   sel,
    input  logic                   inc,
    input  logic                   clr,
    output logic                   at_max
  );

  localparam int LEVELS = 1 << LOOP_ID_W;

  logic [LOOP_ITER_W-1:0] max_q [LEVELS];
  logic [LOOP_ITER_W-1:0] cnt_q [LEVELS];

  // Trip-count writes from the configuration path
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LEVELS; i++) max_q[i] <= '0;
    end else if (wr_en) begin
      max_q[wr_idx] <= wr_data;
    end
  end

  // Iteration counters: bulk clear at run start, otherwise per-level step/wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LEVELS; i++) cnt_q[i] <= '0;
    end else if (clr_all) begin
      for (int i = 0; i < LEVELS; i++) cnt_q[i] <= '0;
    end else if (clr) begin
      cnt_q[sel] <= '0;
    end else if (inc) begin
      cnt_q[sel] <= cnt_q[sel] + LOOP_ITER_W'(1);
    end
  end

  // Equality compare, so an all-ones max yields the full 2**LOOP_ITER_W trips
  assign at_max = (cnt_q[sel] == max_q[sel]);

endmodule

// File: rtl/mem_loop_ctrl.sv
// Nested-loop sequencer top: FSM, current level (lvl), configured level count
// and strobe decode. Level 0 is the innermost loop.
// Optional feature macro: MEM_LOOP_CTRL_PERF_CNT_EN adds saturating 32-bit
// busy/stall cycle counters, cleared when a run is started.
//
// state | meaning
// IDLE  | accepting config writes, waiting for start
// INIT  | first cycle of a run, counters cleared
// ENTER | descending one level per cycle toward level 0
// BUSY  | stepping the innermost loop
// EXIT  | climbing: wrap finished levels, or advance the first unfinished one
// DONE  | one-cycle completion pulse, config cleared
module mem_loop_ctrl
  import mem_loop_ctrl_pkg::*;
  #(
    parameter int LOOP_ID_W   = LOOP_ID_W_DEF,
    parameter int LOOP_ITER_W = LOOP_ITER_W_DEF
  )
  (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_loop_iter_v,
    input  logic [LOOP_ITER_W-1:0] cfg_loop_iter,
    input  logic                   start,
    input  logic                   stall,
    output logic                   busy,
    output logic [LOOP_ID_W-1:0]   loop_index,
    output logic                   loop_index_valid,
    output logic                   loop_init,
    output logic                   loop_enter,
    output logic                   loop_exit,
    output logic                   loop_ctrl_done
`ifdef MEM_LOOP_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]            perf_busy_cycles,
    output logic [31:0]            perf_stall_cycles
`endif
  );

  localparam logic [LOOP_ID_W:0] MAX_LOOPS = {1'b1, {LOOP_ID_W{1'b0}}};
  localparam logic [LOOP_ID_W:0] ONE_LOOP  = {{LOOP_ID_W{1'b0}}, 1'b1};

  state_t                 state;
  logic [LOOP_ID_W-1:0]   lvl;
  logic [LOOP_ID_W:0]     num_loops;
  logic [LOOP_ID_W-1:0]   top_lvl;
  logic                   run;
  logic                   cfg_accept;
  logic                   stepping;
  logic                   last_lvl;
  logic                   at_max;
  logic                   clr_all;

  assign run        = !stall;
  assign busy       = (state != S_IDLE);
  assign cfg_accept = (state == S_IDLE) && cfg_loop_iter_v && (num_loops != MAX_LOOPS);
  assign stepping   = run && ((state == S_BUSY) || (state == S_EXIT));
  assign clr_all    = run && (state == S_INIT);
  assign last_lvl   = (({1'b0, lvl} + ONE_LOOP) == num_loops);
  // num_loops is >= 1 whenever this is used; 32 levels wraps cleanly to 31
  assign top_lvl    = num_loops[LOOP_ID_W-1:0] - LOOP_ID_W'(1);

  loop_counter_bank #(
    .LOOP_ID_W   (LOOP_ID_W),
    .LOOP_ITER_W (LOOP_ITER_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (cfg_accept),
    .wr_idx  (num_loops[LOOP_ID_W-1:0]),
    .wr_data (cfg_loop_iter),
    .clr_all (clr_all),
    .sel     (lvl),
    .inc     (stepping && !at_max),
    .clr     (stepping && at_max),
    .at_max  (at_max)
  );

  // Sequencer FSM with level tracking and configured-depth bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      lvl       <= '0;
      num_loops <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_accept) num_loops <= num_loops + ONE_LOOP;
          if (start) state <= (num_loops == '0) ? S_DONE : S_INIT;
        end
        S_INIT: begin
          if (run) begin
            lvl   <= top_lvl;
            state <= S_ENTER;
          end
        end
        S_ENTER: begin
          if (run) begin
            if (lvl == '0) state <= S_BUSY;
            else           lvl   <= lvl - LOOP_ID_W'(1);
          end
        end
        S_BUSY: begin
          if (run && at_max) begin
            if (num_loops == ONE_LOOP) begin
              state <= S_DONE;
            end else begin
              lvl   <= LOOP_ID_W'(1);
              state <= S_EXIT;
            end
          end
        end
        S_EXIT: begin
          if (run) begin
            if (at_max) begin
              if (last_lvl) state <= S_DONE;
              else          lvl   <= lvl + LOOP_ID_W'(1);
            end else begin
              lvl   <= lvl - LOOP_ID_W'(1);
              state <= S_ENTER;
            end
          end
        end
        S_DONE: begin
          num_loops <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobe decode from registered state; stall blanks every strobe except done
  always_comb begin
    loop_init        = 1'b0;
    loop_enter       = 1'b0;
    loop_exit        = 1'b0;
    loop_index_valid = 1'b0;
    loop_ctrl_done   = (state == S_DONE);
    loop_index       = '0;
    if (run) begin
      case (state)
        S_INIT: begin
          loop_init  = 1'b1;
          loop_index = top_lvl;
        end
        S_ENTER: begin
          loop_enter = 1'b1;
          loop_index = lvl;
        end
        S_BUSY: begin
          loop_index_valid = 1'b1;
        end
        S_EXIT: begin
          loop_exit        = 1'b1;
          loop_index_valid = !at_max;
          loop_index       = lvl;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_LOOP_CTRL_PERF_CNT_EN
  // Saturating activity counters, zeroed when a run is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if ((state == S_IDLE) && start) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && (perf_busy_cycles != '1))
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (busy && stall && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_loop_ctrl.sv
// Directed bench for mem_loop_ctrl. Honours MEM_LOOP_CTRL_PERF_CNT_EN when
// defined to connect and check the performance counters.
module tb_mem_loop_ctrl;

  localparam int IDW = 5;
  localparam int ITW = 16;

  // strobe pattern bits: {init, enter, valid, exit, done}
  localparam logic [4:0] P_0 = 5'b00000;
  localparam logic [4:0] P_I = 5'b10000;
  localparam logic [4:0] P_E = 5'b01000;
  localparam logic [4:0] P_V = 5'b00100;
  localparam logic [4:0] P_X = 5'b00110;
  localparam logic [4:0] P_x = 5'b00010;
  localparam logic [4:0] P_D = 5'b00001;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_loop_iter_v;
  logic [ITW-1:0] cfg_loop_iter;
  logic           start;
  logic           stall;
  logic           busy;
  logic [IDW-1:0] loop_index;
  logic           loop_index_valid;
  logic           loop_init;
  logic           loop_enter;
  logic           loop_exit;
  logic           loop_ctrl_done;
`ifdef MEM_LOOP_CTRL_PERF_CNT_EN
  logic [31:0]    perf_busy_cycles;
  logic [31:0]    perf_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  mem_loop_ctrl #(.LOOP_ID_W(IDW), .LOOP_ITER_W(ITW)) dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_loop_iter_v  (cfg_loop_iter_v),
    .cfg_loop_iter    (cfg_loop_iter),
    .start            (start),
    .stall            (stall),
    .busy             (busy),
    .loop_index       (loop_index),
    .loop_index_valid (loop_index_valid),
    .loop_init        (loop_init),
    .loop_enter       (loop_enter),
    .loop_exit        (loop_exit),
    .loop_ctrl_done   (loop_ctrl_done)
`ifdef MEM_LOOP_CTRL_PERF_CNT_EN
    ,
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] strobes();
    return {loop_init, loop_enter, loop_index_valid, loop_exit, loop_ctrl_done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: apply stall, check strobes (and index when a leveled strobe is expected), advance
  task automatic cyc(input string tag, input logic s, input logic [4:0] pat, input logic [IDW-1:0] idx);
    stall = s;
    #1;
    chk({tag, " strobes"}, 32'(strobes()), 32'(pat));
    if (pat[4:1] != 4'b0000) chk({tag, " index"}, 32'(loop_index), 32'(idx));
    tick();
  endtask

  task automatic cfg(input logic [ITW-1:0] v);
    cfg_loop_iter_v = 1'b1;
    cfg_loop_iter   = v;
    tick();
    cfg_loop_iter_v = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    stall = 1'b0;
    #1;
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " quiet"}, 32'(strobes()), 32'(P_0));
  endtask

  int  n_valid;
  bit  seen;

  initial begin
    reset = 1'b1; cfg_loop_iter_v = 1'b0; cfg_loop_iter = '0; start = 1'b0; stall = 1'b0;
    tick(); tick();
    reset = 1'b0;
    idle_chk("reset");
    chk("reset index", 32'(loop_index), 32'd0);

    // Scenario 1: max={2,1}
    cfg(16'd2); cfg(16'd1);
    kick();
    #1; chk("s1 busy t1", 32'(busy), 32'd1);
    cyc("s1 t1", 0, P_I, 1);
    cyc("s1 t2", 0, P_E, 1);
    cyc("s1 t3", 0, P_E, 0);
    cyc("s1 t4", 0, P_V, 0);
    cyc("s1 t5", 0, P_V, 0);
    cyc("s1 t6", 0, P_V, 0);
    cyc("s1 t7", 0, P_X, 1);
    cyc("s1 t8", 0, P_E, 0);
    cyc("s1 t9", 0, P_V, 0);
    cyc("s1 t10", 0, P_V, 0);
    cyc("s1 t11", 0, P_V, 0);
    cyc("s1 t12", 0, P_x, 1);
    cyc("s1 t13", 0, P_D, 0);
    idle_chk("s1 end");

    // Scenario 2: single level max={4}
    cfg(16'd4);
    kick();
    cyc("s2 t1", 0, P_I, 0);
    cyc("s2 t2", 0, P_E, 0);
    cyc("s2 t3", 0, P_V, 0);
    cyc("s2 t4", 0, P_V, 0);
    cyc("s2 t5", 0, P_V, 0);
    cyc("s2 t6", 0, P_V, 0);
    cyc("s2 t7", 0, P_V, 0);
    cyc("s2 t8", 0, P_D, 0);
    idle_chk("s2 end");

    // Scenario 3: start with nothing configured
    kick();
    cyc("s3 t1", 0, P_D, 0);
    idle_chk("s3 end");

    // Scenario 4: scenario 1 with stall held for t5..t7
    cfg(16'd2); cfg(16'd1);
    kick();
    cyc("s4 t1", 0, P_I, 1);
    cyc("s4 t2", 0, P_E, 1);
    cyc("s4 t3", 0, P_E, 0);
    cyc("s4 t4", 0, P_V, 0);
    cyc("s4 t5", 1, P_0, 0);
    cyc("s4 t6", 1, P_0, 0);
    cyc("s4 t7", 1, P_0, 0);
    cyc("s4 t8", 0, P_V, 0);
    cyc("s4 t9", 0, P_V, 0);
    cyc("s4 t10", 0, P_X, 1);
    cyc("s4 t11", 0, P_E, 0);
    cyc("s4 t12", 0, P_V, 0);
    cyc("s4 t13", 0, P_V, 0);
    cyc("s4 t14", 0, P_V, 0);
    cyc("s4 t15", 0, P_x, 1);
    cyc("s4 t16", 0, P_D, 0);
    idle_chk("s4 end");
`ifdef MEM_LOOP_CTRL_PERF_CNT_EN
    chk("perf busy", perf_busy_cycles, 32'd16);
    chk("perf stall", perf_stall_cycles, 32'd3);
`endif

    // Scenario 5a: 33 writes saturate at 32 levels; cfg during the run is dropped
    for (int i = 0; i < 33; i++) cfg(16'd0);
    kick();
    cyc("s5 init", 0, P_I, 5'd31);
    n_valid = 0;
    seen    = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      cfg_loop_iter_v = 1'b1;
      cfg_loop_iter   = 16'd5;
      #1;
      if (loop_index_valid) n_valid++;
      if (loop_ctrl_done) seen = 1'b1;
      tick();
    end
    cfg_loop_iter_v = 1'b0;
    chk("s5 done seen", 32'(seen), 32'd1);
    chk("s5 valid count", n_valid, 32'd1);
    idle_chk("s5 end");
    kick();
    cyc("s5 no cfg", 0, P_D, 0);
    idle_chk("s5 no cfg end");

    // Scenario 5b: reset during t6 of scenario 1
    cfg(16'd2); cfg(16'd1);
    kick();
    cyc("s5r t1", 0, P_I, 1);
    cyc("s5r t2", 0, P_E, 1);
    cyc("s5r t3", 0, P_E, 0);
    cyc("s5r t4", 0, P_V, 0);
    cyc("s5r t5", 0, P_V, 0);
    reset = 1'b1;
    cyc("s5r t6", 0, P_V, 0);
    reset = 1'b0;
    idle_chk("s5r t7");
    tick();
    kick();
    cyc("s5r fresh", 0, P_D, 0);
    idle_chk("s5r fresh end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
